pipeline_stage_register: RTL and testbench

PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

---
 rtl/pipeline_stage_register.sv | 148 ++++++++++++++
 tb/tb_pipeline_stage_register.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register
// Two-entry elastic pipeline stage (main + skid) carrying a datapath payload
// and a control bundle between valid/ready handshakes.
//
// Parameters
//   DATA_WIDTH    datapath payload width
//   CONTROL_WIDTH control-signal bundle width
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   clear                    synchronous flush, discards both entries
//   in_valid/in_ready        upstream handshake, in_data/in_control payload
//   out_valid/out_ready      downstream handshake, out_data/out_control payload
//   stall_count/bubble_count saturating statistics counters
// Build option
//   PIPELINE_STAGE_STATS_EN  enables the statistics counters; when undefined
//                            both counters read as constant zero.
module pipeline_stage_register #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CONTROL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [CONTROL_WIDTH-1:0] in_control,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CONTROL_WIDTH-1:0] out_control,
    output logic [31:0]              stall_count,
    output logic [31:0]              bubble_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_main_data;
    logic [CONTROL_WIDTH-1:0] r_main_control;
    logic [DATA_WIDTH-1:0]    r_skid_data;
    logic [CONTROL_WIDTH-1:0] r_skid_control;

    logic w_accept;
    logic w_deliver;

    // Handshakes qualified by registered flags only; no out_ready -> in_ready path.
    assign w_accept  = in_valid  && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // State, entries and handshake flags. Main control is zeroed whenever the
    // stage goes empty so a bubble never presents a live control bundle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_EMPTY;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_main_data    <= '0;
            r_main_control <= '0;
            r_skid_data    <= '0;
            r_skid_control <= '0;
        end else if (clear) begin
            // Flush wins over both handshakes; an offered beat is dropped.
            r_state        <= ST_EMPTY;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_main_control <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data    <= in_data;
                        r_main_control <= in_control;
                        r_state        <= ST_ONE;
                        r_out_valid    <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_deliver) begin
                        r_main_data    <= in_data;
                        r_main_control <= in_control;
                    end else if (w_accept) begin
                        r_skid_data    <= in_data;
                        r_skid_control <= in_control;
                        r_state        <= ST_FULL;
                        r_in_ready     <= 1'b0;
                    end else if (w_deliver) begin
                        r_main_control <= '0;
                        r_state        <= ST_EMPTY;
                        r_out_valid    <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_deliver) begin
                        r_main_data    <= r_skid_data;
                        r_main_control <= r_skid_control;
                        r_state        <= ST_ONE;
                        r_in_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_EMPTY;
                    r_in_ready     <= 1'b1;
                    r_out_valid    <= 1'b0;
                    r_main_control <= '0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_main_data;
    assign out_control = r_main_control;

`ifdef PIPELINE_STAGE_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_bubble_count;

    // Saturating counters; unaffected by clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count  <= '0;
            r_bubble_count <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (!r_out_valid && (r_bubble_count != 32'hFFFF_FFFF)) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign stall_count  = r_stall_count;
    assign bubble_count = r_bubble_count;
`else
    assign stall_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Testbench for pipeline_stage_register: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_pipeline_stage_register;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_control;
    logic [31:0] stall_count;
    logic [31:0] bubble_count;

    pipeline_stage_register #(.DATA_WIDTH(32), .CONTROL_WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_control   (in_control),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_control  (out_control),
        .stall_count  (stall_count),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered queue of beats {control, data}, capacity 2.
    logic [39:0] q[$];
    longint unsigned m_stall;
    longint unsigned m_bubble;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [39:0] head;
        logic [63:0] exp_stall;
        logic [63:0] exp_bubble;
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            head = q[0];
            check("out_data",    64'(out_data),    64'(head[31:0]));
            check("out_control", 64'(out_control), 64'(head[39:32]));
        end else begin
            check("bubble_control", 64'(out_control), 64'd0);
        end
`ifdef PIPELINE_STAGE_STATS_EN
        exp_stall  = (m_stall  > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_stall);
        exp_bubble = (m_bubble > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_bubble);
`else
        exp_stall  = 64'd0;
        exp_bubble = 64'd0;
`endif
        check("stall_count",  64'(stall_count),  exp_stall);
        check("bubble_count", 64'(bubble_count), exp_bubble);
    endtask

    // One clock: check at negedge, drive, clock, advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic r, input logic clr);
        int  sz;
        bit  acc;
        bit  del;
        check_outputs();
        in_valid   = v;
        in_data    = d;
        in_control = c;
        out_ready  = r;
        clear      = clr;
        sz  = q.size();
        acc = v && (sz < 2) && !clr;
        del = (sz > 0) && r && !clr;
        if (sz > 0 && !r) m_stall++;
        if (sz == 0)      m_bubble++;
        @(posedge clk);
        if (clr) begin
            q.delete();
        end else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back({c, d});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; in_control = '0; out_ready = 1'b0; clear = 1'b0;
        reset_n = 1'b0;
        q.delete();
        m_stall = 0;
        m_bubble = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        @(negedge clk);
        do_reset();
        check("reset_out_data", 64'(out_data), 64'd0);
        check_outputs();

        // Stats: 5 idle cycles, one load, 3 stalled cycles.
        repeat (5) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
`ifdef PIPELINE_STAGE_STATS_EN
        check("bubble_after_idle", 64'(bubble_count), 64'd5);
`else
        check("bubble_disabled", 64'(bubble_count), 64'd0);
`endif
        step(1'b1, 32'h55, 8'h01, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
`ifdef PIPELINE_STAGE_STATS_EN
        check("stall_after_3", 64'(stall_count), 64'd3);
`else
        check("stall_disabled", 64'(stall_count), 64'd0);
`endif
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Streaming 0x11..0x14, one cycle latency, in_ready held high.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(8'h11 + i), 8'(i), 1'b1, 1'b0);
            check("stream_data",  64'(out_data), 64'(8'h11 + i));
            check("stream_ready", 64'(in_ready), 64'd1);
        end
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Backpressure: fill with A,B then drain in order.
        step(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check("drain_second", 64'(out_data), 64'hB);
        check("ready_after_first", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Flush while FULL with a simultaneous offer of 0xC.
        step(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
        step(1'b1, 32'hC, 8'h0C, 1'b0, 1'b1);
        check("flush_valid", 64'(out_valid), 64'd0);
        repeat (2) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);

        // Bubble control: FF control drained leaves zero control.
        step(1'b1, 32'h77, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check("drained_control", 64'(out_control), 64'd0);

        // Async reset while FULL.
        step(1'b1, 32'hA, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'hBB, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_out_control", 64'(out_control), 64'd0);
        @(negedge clk);
        do_reset();
        step(1'b1, 32'h99, 8'h09, 1'b0, 1'b0);
        check("first_after_reset", 64'(out_data), 64'h99);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
